// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic request to 32-bit MIPS word encoder with LI32 expansion.
// Optional build macro MIPS_ENC_FUNCT_CHECK_EN restricts R-type funct values to a legal set.
module mips_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [0:0] {IDLE, EMIT2} state_t;

  localparam logic [5:0] OPC_R     = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_rt_q, pend_rt_d;
  logic [15:0]      pend_lo_q, pend_lo_d;

  logic        funct_ok;
  logic        legal;
  logic        two_words;
  logic        li_short;
  logic [15:0] li_hi;
  logic [31:0] word0;
  logic        accept;
  logic        fire;

  always_comb begin
    funct_ok = 1'b1;
`ifdef MIPS_ENC_FUNCT_CHECK_EN
    case (in_funct)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: funct_ok = 1'b1;
      default:      funct_ok = 1'b0;
    endcase
`endif
  end

  // LI32 fits one ADDIU when imm sign-extends from bit 15; the LUI half
  // pre-compensates for the sign extension ADDIU applies to the low half.
  assign li_short = (&in_imm[31:15]) || (~|in_imm[31:15]);
  assign li_hi    = in_imm[31:16] + {15'd0, in_imm[15]};

  always_comb begin
    legal     = 1'b1;
    two_words = 1'b0;
    word0     = 32'd0;
    case (in_op)
      4'd0:  begin
        word0 = {OPC_R, in_rs, in_rt, in_rd, in_shamt, in_funct};
        legal = funct_ok;
      end
      4'd1:  word0 = {OPC_ADDI,  in_rs, in_rt, in_imm[15:0]};
      4'd2:  word0 = {OPC_ADDIU, in_rs, in_rt, in_imm[15:0]};
      4'd3:  word0 = {OPC_SLTI,  in_rs, in_rt, in_imm[15:0]};
      4'd4:  word0 = {OPC_SLTIU, in_rs, in_rt, in_imm[15:0]};
      4'd5:  word0 = {OPC_ANDI,  in_rs, in_rt, in_imm[15:0]};
      4'd6:  word0 = {OPC_LUI,   5'd0,  in_rt, in_imm[15:0]};
      4'd7:  word0 = {OPC_LW,    in_rs, in_rt, in_imm[15:0]};
      4'd8:  word0 = {OPC_SW,    in_rs, in_rt, in_imm[15:0]};
      4'd9:  word0 = {OPC_BEQ,   in_rs, in_rt, in_imm[15:0]};
      4'd10: word0 = {OPC_J,     in_imm[27:2]};
      4'd11: word0 = {OPC_JAL,   in_imm[27:2]};
      4'd12: begin
        if (li_short) begin
          word0 = {OPC_ADDIU, 5'd0, in_rt, in_imm[15:0]};
        end else begin
          word0     = {OPC_LUI, 5'd0, in_rt, li_hi};
          two_words = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    pend_rt_d   = pend_rt_q;
    pend_lo_d   = pend_lo_q;

    if (fire) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = word0;
            out_last_d  = !two_words;
            if (two_words) begin
              state_d   = EMIT2;
              pend_rt_d = in_rt;
              pend_lo_d = in_imm[15:0];
            end
          end
        end
      end
      EMIT2: begin
        // The LUI word is held until taken; the ADDIU follows on the next cycle.
        if (fire) begin
          out_valid_d = 1'b1;
          out_instr_d = {OPC_ADDIU, pend_rt_q, pend_rt_q, pend_lo_q};
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      pend_rt_q   <= 5'd0;
      pend_lo_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pend_rt_q   <= pend_rt_d;
      pend_lo_q   <= pend_lo_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_last    = out_last_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - randomized and directed bench for mips_instr_encoder against a queue model.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [5:0]  in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;
  logic [15:0] instr_count;

  mips_instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last),
    .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } item_t;

  item_t       q[$];
  logic [15:0] cnt_m;
  logic        err_exp;
  bit          chk_en = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit r_funct_legal(input logic [5:0] f);
`ifdef MIPS_ENC_FUNCT_CHECK_EN
    return f inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b};
`else
    return 1'b1;
`endif
  endfunction

  // Pushes the words a request must produce; returns 0 when it must be rejected.
  function automatic bit model_accept(input logic [3:0] op, input logic [5:0] f,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [31:0] imm);
    logic [31:0] opc_tab [0:11];
    logic [31:0] lo16, w, lo_sext, hi;
    int signed   sv;
    opc_tab = '{32'h00, 32'h08, 32'h09, 32'h0a, 32'h0b, 32'h0c, 32'h0f, 32'h23, 32'h2b, 32'h04, 32'h02, 32'h03};
    lo16 = imm & 32'hFFFF;
    if (op > 4'd12) return 1'b0;
    if (op == 4'd0) begin
      if (!r_funct_legal(f)) return 1'b0;
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(f);
      q.push_back('{w, 1'b1});
    end else if (op == 4'd6) begin
      q.push_back('{(32'h0f << 26) | (32'(rt) << 16) | lo16, 1'b1});
    end else if (op == 4'd10 || op == 4'd11) begin
      q.push_back('{(opc_tab[op] << 26) | ((imm >> 2) & 32'h03FF_FFFF), 1'b1});
    end else if (op == 4'd12) begin
      sv = $signed(imm);
      if (sv >= -32768 && sv <= 32767) begin
        q.push_back('{(32'h09 << 26) | (32'(rt) << 16) | lo16, 1'b1});
      end else begin
        lo_sext = (lo16 >= 32'h8000) ? (lo16 | 32'hFFFF_0000) : lo16;
        hi = (imm - lo_sext) >> 16;
        q.push_back('{(32'h0f << 26) | (32'(rt) << 16) | hi, 1'b0});
        q.push_back('{(32'h09 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo16, 1'b1});
      end
    end else begin
      q.push_back('{(opc_tab[op] << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo16, 1'b1});
    end
    return 1'b1;
  endfunction

  // Inputs change #1 after posedge, so at negedge both the present outputs and
  // the handshakes of the coming edge are known.
  always @(negedge clk) begin
    bit rdy_exp;
    bit fire_m;
    rdy_exp = (q.size() == 0) || (q.size() == 1 && q[0].last && out_ready);
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_instr", out_instr, q[0].w);
        check("out_last", 32'(out_last), 32'(q[0].last));
      end
      check("err", 32'(err), 32'(err_exp));
      check("instr_count", 32'(instr_count), 32'(cnt_m));
      check("in_ready", 32'(in_ready), 32'(rdy_exp));
    end
    if (!rst_n) begin
      q.delete();
      cnt_m   = 16'd0;
      err_exp = 1'b0;
      chk_en  = 1;
    end else if (chk_en) begin
      fire_m  = (q.size() > 0) && out_ready;
      err_exp = 1'b0;
      if (fire_m) begin
        void'(q.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (in_valid && rdy_exp) begin
        if (!model_accept(in_op, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm)) err_exp = 1'b1;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [5:0] f, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [31:0] imm);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_funct = f; in_rs = rs; in_rt = rt;
    in_rd = rd; in_shamt = sh; in_imm = imm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_word(input string name, input logic [31:0] w, input logic last);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check(name, out_instr, w);
        check({name, "_last"}, 32'(out_last), 32'(last));
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] c0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_funct = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_shamt = '0; in_imm = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send(4'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    get_word("addu", 32'h00221821, 1'b1);
    send(4'd0, 6'h00, 5'd0, 5'd5, 5'd4, 5'd2, 32'd0);
    get_word("sll", 32'h00052080, 1'b1);
    send(4'd7, 6'd0, 5'd29, 5'd9, 5'd0, 5'd0, 32'd4);
    get_word("lw", 32'h8FA90004, 1'b1);
    send(4'd9, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000FFFE);
    get_word("beq", 32'h1022FFFE, 1'b1);
    send(4'd11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00400010);
    get_word("jal", 32'h0C100004, 1'b1);

    c0 = cnt_m;
    out_ready = 1'b0;
    send(4'd12, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12348765);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_instr", out_instr, 32'h3C081235);
      check("bp_last", 32'(out_last), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_count", 32'(instr_count), 32'(c0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    get_word("li32_lui", 32'h3C081235, 1'b0);
    get_word("li32_addiu", 32'h25088765, 1'b1);
    check("bp_count_after", 32'(instr_count), 32'(c0 + 16'd2));

    send(4'd12, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFFFFF0);
    get_word("li32_short", 32'h2408FFF0, 1'b1);

    send(4'd14, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_no_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("illegal_err_pulse", 32'(err), 32'd0);
    send(4'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    get_word("after_illegal", 32'h00221821, 1'b1);

`ifdef MIPS_ENC_FUNCT_CHECK_EN
    send(4'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    check("funct_err", 32'(err), 32'd1);
    check("funct_no_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
`endif

    out_ready = 1'b0;
    send(4'd12, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12348765);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("emit2_rst_valid", 32'(out_valid), 32'd0);
    check("emit2_rst_count", 32'(instr_count), 32'd0);
    check("emit2_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_funct  = 6'($urandom);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_shamt  = 5'($urandom);
      case ($urandom_range(0, 2))
        0: in_imm = {{16{1'($urandom)}}, 16'($urandom)};
        1: in_imm = {16'($urandom_range(0, 1) ? 16'h0000 : 16'hFFFF), 1'($urandom), 15'($urandom)};
        default: in_imm = $urandom;
      endcase
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
